// File: rtl/jellyvl_etherneco_pkg.sv
// Shared constants, state type and CRC-32 helper for the etherneco TX framer.
package jellyvl_etherneco_pkg;

  localparam logic [7:0]  PREAMBLE_BYTE        = 8'h55;
  localparam logic [7:0]  SFD_BYTE             = 8'hD5;
  localparam logic [31:0] CRC32_POLY_REFLECTED = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT           = 32'hFFFFFFFF;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    SFD,
    PAYLOAD,
    FCS,
    IFG
  } tx_state_t;

  // Reflected CRC-32 advanced by one byte, LSB of the byte first.
  function automatic logic [31:0] crc32_update_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h000000, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFLECTED) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/jellyvl_etherneco_crc32.sv
// Byte-wide registered reflected CRC-32 generator (running value, not inverted).
module jellyvl_etherneco_crc32
  import jellyvl_etherneco_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic [7:0]  data,
  input  logic        valid,
  output logic [31:0] crc
);

  logic [31:0] crc_q;
  logic [31:0] crc_d;

  // Clear has priority so a new frame always starts from the initial value.
  always_comb begin
    crc_d = crc_q;
    if (clear) begin
      crc_d = CRC32_INIT;
    end else if (valid) begin
      crc_d = crc32_update_byte(crc_q, data);
    end
  end

  // CRC state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      crc_q <= CRC32_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/jellyvl_etherneco_packet_tx.sv
// Etherneco ring-port TX framer: byte FIFO, preamble/SFD insertion, optional
// FCS and inter-frame gap. Define JELLYVL_ETHERNECO_PACKET_TX_FCS_EN to append
// the 4-byte FCS; without it m_tx_last marks the last payload byte.
module jellyvl_etherneco_packet_tx
  import jellyvl_etherneco_pkg::*;
#(
  parameter int FIFO_PTR_WIDTH = 6,
  parameter int PREAMBLE_LEN   = 7,
  parameter int IFG_CYCLES     = 12,
  parameter int IFG_WIDTH      = 8
) (
  input  logic       clk,
  input  logic       reset,

  input  logic       s_first,
  input  logic       s_last,
  input  logic [7:0] s_data,
  input  logic       s_valid,

  output logic       m_tx_first,
  output logic       m_tx_last,
  output logic [7:0] m_tx_data,
  output logic       m_tx_valid,
  input  logic       m_tx_ready,

  output logic       busy,
  output logic       overflow,
  output logic       underrun
);

  localparam int DEPTH = 1 << FIFO_PTR_WIDTH;
  localparam int PRE_W = $clog2(PREAMBLE_LEN + 1);
  localparam logic [FIFO_PTR_WIDTH:0] PTR_ONE = (FIFO_PTR_WIDTH + 1)'(1);

  // Frame start is inferred from the FIFO going non-empty, so s_first is not needed.
  logic unused_s_first;
  assign unused_s_first = s_first;

  // FIFO storage: {last, data}
  logic [8:0]              fifo_mem [0:DEPTH-1];
  logic [FIFO_PTR_WIDTH:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_PTR_WIDTH:0] rd_ptr_q, rd_ptr_d;
  logic                    fifo_empty, fifo_full, fifo_wr, fifo_pop;
  logic [8:0]              rd_entry;

  tx_state_t        state_q;
  logic [PRE_W-1:0] pre_cnt_q;
  logic [IFG_WIDTH-1:0] ifg_cnt_q;
  logic             m_tx_first_q, m_tx_last_q, m_tx_valid_q;
  logic [7:0]       m_tx_data_q;
  logic             overflow_q, underrun_q;
  logic             out_free;
  logic             sfd_load;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[FIFO_PTR_WIDTH] != rd_ptr_q[FIFO_PTR_WIDTH]) &&
                      (wr_ptr_q[FIFO_PTR_WIDTH-1:0] == rd_ptr_q[FIFO_PTR_WIDTH-1:0]);
  // Full is judged on the current pointers, so a same-cycle pop cannot make room.
  assign fifo_wr    = s_valid && !fifo_full;
  assign rd_entry   = fifo_mem[rd_ptr_q[FIFO_PTR_WIDTH-1:0]];

  // Output slot can take a new byte when empty or being accepted this cycle.
  assign out_free   = !m_tx_valid_q || m_tx_ready;
  assign fifo_pop   = ((state_q == SFD) || (state_q == PAYLOAD)) && out_free && !fifo_empty;
  assign sfd_load   = (state_q == PREAMBLE) && out_free && (pre_cnt_q == PRE_W'(PREAMBLE_LEN));

  assign wr_ptr_d   = fifo_wr  ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
  assign rd_ptr_d   = fifo_pop ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

`ifdef JELLYVL_ETHERNECO_PACKET_TX_FCS_EN
  logic [31:0] crc_w;
  logic [31:0] fcs_w;
  logic [1:0]  fcs_cnt_q;

  jellyvl_etherneco_crc32 u_crc32 (
    .clk   (clk),
    .reset (reset),
    .clear (sfd_load),
    .data  (rd_entry[7:0]),
    .valid (fifo_pop),
    .crc   (crc_w)
  );

  assign fcs_w = ~crc_w;
`else
  logic unused_sfd_load;
  assign unused_sfd_load = sfd_load;
`endif

  // FIFO memory write; no reset so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      fifo_mem[wr_ptr_q[FIFO_PTR_WIDTH-1:0]] <= {s_last, s_data};
    end
  end

  // Write pointer and sticky overflow on a dropped input byte.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      if (s_valid && fifo_full) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Framing FSM with registered output byte; state names the byte currently presented.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      rd_ptr_q     <= '0;
      pre_cnt_q    <= '0;
      ifg_cnt_q    <= '0;
      m_tx_first_q <= 1'b0;
      m_tx_last_q  <= 1'b0;
      m_tx_valid_q <= 1'b0;
      m_tx_data_q  <= 8'h00;
      underrun_q   <= 1'b0;
`ifdef JELLYVL_ETHERNECO_PACKET_TX_FCS_EN
      fcs_cnt_q    <= 2'd0;
`endif
    end else begin
      rd_ptr_q <= rd_ptr_d;
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            m_tx_valid_q <= 1'b1;
            m_tx_first_q <= 1'b1;
            m_tx_last_q  <= 1'b0;
            m_tx_data_q  <= PREAMBLE_BYTE;
            pre_cnt_q    <= PRE_W'(1);
            state_q      <= PREAMBLE;
          end
        end

        PREAMBLE: begin
          if (out_free) begin
            m_tx_valid_q <= 1'b1;
            m_tx_first_q <= 1'b0;
            if (sfd_load) begin
              m_tx_data_q <= SFD_BYTE;
              state_q     <= SFD;
            end else begin
              m_tx_data_q <= PREAMBLE_BYTE;
              pre_cnt_q   <= pre_cnt_q + PRE_W'(1);
            end
          end
        end

        SFD, PAYLOAD: begin
          if (out_free) begin
            m_tx_first_q <= 1'b0;
            if (fifo_pop) begin
              m_tx_valid_q <= 1'b1;
              m_tx_data_q  <= rd_entry[7:0];
              if (rd_entry[8]) begin
`ifdef JELLYVL_ETHERNECO_PACKET_TX_FCS_EN
                fcs_cnt_q <= 2'd0;
                state_q   <= FCS;
`else
                m_tx_last_q <= 1'b1;
                state_q     <= IFG;
`endif
              end else begin
                state_q <= PAYLOAD;
              end
            end else begin
              // Frame still open but nothing buffered: stall the output.
              m_tx_valid_q <= 1'b0;
              underrun_q   <= 1'b1;
              state_q      <= PAYLOAD;
            end
          end
        end

`ifdef JELLYVL_ETHERNECO_PACKET_TX_FCS_EN
        FCS: begin
          if (out_free) begin
            m_tx_valid_q <= 1'b1;
            m_tx_data_q  <= fcs_w[{fcs_cnt_q, 3'b000} +: 8];
            fcs_cnt_q    <= fcs_cnt_q + 2'd1;
            if (fcs_cnt_q == 2'd3) begin
              m_tx_last_q <= 1'b1;
              state_q     <= IFG;
            end
          end
        end
`endif

        IFG: begin
          if (m_tx_valid_q) begin
            // Wait for the final byte to be taken before the gap starts.
            if (m_tx_ready) begin
              m_tx_valid_q <= 1'b0;
              m_tx_last_q  <= 1'b0;
              if (IFG_CYCLES <= 1) begin
                state_q <= IDLE;
              end else begin
                ifg_cnt_q <= IFG_WIDTH'(1);
              end
            end
          end else if (ifg_cnt_q >= IFG_WIDTH'(IFG_CYCLES - 1)) begin
            // IDLE spends one more idle clock before presenting the preamble.
            state_q <= IDLE;
          end else begin
            ifg_cnt_q <= ifg_cnt_q + IFG_WIDTH'(1);
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign m_tx_first = m_tx_first_q;
  assign m_tx_last  = m_tx_last_q;
  assign m_tx_data  = m_tx_data_q;
  assign m_tx_valid = m_tx_valid_q;
  assign busy       = (state_q != IDLE);
  assign overflow   = overflow_q;
  assign underrun   = underrun_q;

endmodule
